// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared constants for the data-RAM arbiter.
//   - arb_state_e : scheduler states; the state records the last grantee,
//                   which is what drives the round-robin choice.
//   - owner_e     : tag carried with an issued read so the returned data
//                   can be steered to the right master's rvalid.
//   - DEF_*       : default RAM geometry and lock bound.
package ram_arbiter_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_LOCK = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_LOCK1 = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_arbiter_sched.sv
// rr_lock_sched: grant scheduler for the two-master RAM arbiter.
//   clk, rst        : clock, synchronous active-high reset
//   m0_req, m1_req  : pending transfer requests
//   m1_lock         : master 1 asks to keep the RAM for a burst
//   m0_gnt, m1_gnt  : one-hot (or zero) combinational grants
// Round-robin between the masters; master 1 may hold a lock for at most
// MAX_LOCK consecutive grants while master 0 is waiting.
module rr_lock_sched
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  input  logic m1_lock,
  output logic m0_gnt,
  output logic m1_gnt
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             m1_first;

  // Grant decision and next-state / lock-counter computation.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m1_first   = 1'b0;
    if (rst) begin
      // No grants while in reset; the flops are cleared below.
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
    end else if ((state_q == ST_LOCK1) && m1_req && m1_lock) begin
      if ((lock_cnt_q == CNT_MAX) && m0_req) begin
        // Lock budget spent and m0 waiting: m0 takes this slot.
        m0_gnt     = 1'b1;
        state_d    = ST_OWN0;
        lock_cnt_d = '0;
      end else begin
        // Counter saturates if m0 never shows up.
        m1_gnt     = 1'b1;
        state_d    = ST_LOCK1;
        lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_ONE;
      end
    end else begin
      // Plain round-robin. A dropped lock counts as "m1 was last", so m0 wins a tie.
      m1_first   = (state_q == ST_OWN0);
      lock_cnt_d = '0;
      if (m0_req && (!m1_req || !m1_first)) begin
        m0_gnt  = 1'b1;
        state_d = ST_OWN0;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
        if (m1_lock) begin
          state_d    = ST_LOCK1;
          lock_cnt_d = CNT_ONE;
        end else begin
          state_d = ST_OWN1;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and lock-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous data RAM between the CPU
// load/store path (master 0) and the loader/debug port (master 1).
//   clk, rst                  : clock, synchronous active-high reset
//   mX_req/wr/addr/wdata      : master X transfer request
//   m1_lock                   : master 1 burst lock request
//   mX_gnt                    : request accepted this cycle (combinational)
//   mX_rvalid, mX_rdata       : read return, two cycles after acceptance
//   m0_stall                  : CPU must freeze while its request waits
//   ram_rd/wr/addr/wdata      : registered RAM pins
//   ram_rdata                 : RAM output, valid one cycle after ram_rd
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_stall,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  owner_e            issue_tag_q, issue_tag_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;

  rr_lock_sched #(.MAX_LOCK(MAX_LOCK)) u_sched (
    .clk     (clk),
    .rst     (rst),
    .m0_req  (m0_req),
    .m1_req  (m1_req),
    .m1_lock (m1_lock),
    .m0_gnt  (m0_gnt),
    .m1_gnt  (m1_gnt)
  );

  assign m0_stall = m0_req & ~m0_gnt;

  // Issue stage: the accepted transfer goes to the RAM pins on the next edge;
  // addr/wdata hold when nothing is accepted.
  always_comb begin
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    issue_tag_d = issue_tag_q;
    if (m0_gnt) begin
      ram_rd_d    = ~m0_wr;
      ram_wr_d    = m0_wr;
      ram_addr_d  = m0_addr;
      ram_wdata_d = m0_wdata;
      issue_tag_d = OWNER_M0;
    end else if (m1_gnt) begin
      ram_rd_d    = ~m1_wr;
      ram_wr_d    = m1_wr;
      ram_addr_d  = m1_addr;
      ram_wdata_d = m1_wdata;
      issue_tag_d = OWNER_M1;
    end else begin
      ram_rd_d = 1'b0;
    end
    // The tag of the read on the pins now selects who sees the data next cycle.
    m0_rvalid_d = ram_rd_q & (issue_tag_q == OWNER_M0);
    m1_rvalid_d = ram_rd_q & (issue_tag_q == OWNER_M1);
  end

  // Issue register and read-return tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      issue_tag_q <= OWNER_M0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      issue_tag_q <= issue_tag_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign ram_rd    = ram_rd_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed table, hand-written corner sequences and
// a randomized phase, all checked against a behavioural reference model.
module tb_ram_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MAX_LOCK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_rd, ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_stall(m0_stall),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] shadow [0:255];
  int   mdl_last;     // 0 = nobody, 1 = m0, 2 = m1 was granted last cycle
  bit   mdl_in_lock;  // m1 is running a locked burst
  int   mdl_run;      // locked m1 grants in the current burst
  logic eg0, eg1;     // expected grants this cycle
  // expected pin state (issue) and read return
  logic              ei_rd, ei_wr, ei_own;
  logic [ADDR_W-1:0] ei_addr;
  logic [DATA_W-1:0] ei_wdata, ei_data;
  logic              er_v0, er_v1;
  logic [DATA_W-1:0] er_data;

  task automatic model_grant();
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst) begin
      eg0 = 1'b0;
    end else if (mdl_in_lock && m1_req && m1_lock) begin
      if (m0_req && mdl_run >= MAX_LOCK) eg0 = 1'b1;
      else                               eg1 = 1'b1;
    end else if (m0_req && m1_req) begin
      if (mdl_last == 1) eg1 = 1'b1;
      else               eg0 = 1'b1;
    end else if (m0_req) begin
      eg0 = 1'b1;
    end else if (m1_req) begin
      eg1 = 1'b1;
    end
  endtask

  task automatic model_reset();
    mdl_last = 0; mdl_in_lock = 1'b0; mdl_run = 0;
    ei_rd = 1'b0; ei_wr = 1'b0; ei_own = 1'b0; ei_addr = '0; ei_wdata = '0; ei_data = '0;
    er_v0 = 1'b0; er_v1 = 1'b0; er_data = '0;
  endtask

  // Compare all outputs at the negative edge against the model.
  task automatic sample();
    @(negedge clk);
    model_grant();
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg1});
    chk("m0_stall", {31'd0, m0_stall}, {31'd0, m0_req & ~eg0});
    chk("ram_rd", {31'd0, ram_rd}, {31'd0, ei_rd});
    chk("ram_wr", {31'd0, ram_wr}, {31'd0, ei_wr});
    chk("ram_addr", {24'd0, ram_addr}, {24'd0, ei_addr});
    chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, ei_wdata});
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, er_v0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, er_v1});
    if (er_v0) chk("m0_rdata", {16'd0, m0_rdata}, {16'd0, er_data});
    if (er_v1) chk("m1_rdata", {16'd0, m1_rdata}, {16'd0, er_data});
  endtask

  // Move the model one clock forward and cross the active edge.
  task automatic advance();
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    if (rst) begin
      model_reset();
    end else begin
      er_v0   = ei_rd && !ei_own;
      er_v1   = ei_rd && ei_own;
      er_data = ei_data;
      if (eg0 || eg1) begin
        w = eg1 ? m1_wr : m0_wr;
        a = eg1 ? m1_addr : m0_addr;
        d = eg1 ? m1_wdata : m0_wdata;
        ei_rd = !w; ei_wr = w; ei_addr = a; ei_wdata = d; ei_own = eg1;
        ei_data = shadow[a];
        if (w) shadow[a] = d;
      end else begin
        ei_rd = 1'b0; ei_wr = 1'b0;
      end
      if (eg0) begin
        mdl_last = 1; mdl_in_lock = 1'b0; mdl_run = 0;
      end else if (eg1) begin
        mdl_last = 2;
        if (m1_lock) begin
          mdl_run     = mdl_in_lock ? mdl_run + 1 : 1;
          mdl_in_lock = 1'b1;
        end else begin
          mdl_in_lock = 1'b0; mdl_run = 0;
        end
      end else begin
        mdl_last = 0; mdl_in_lock = 1'b0; mdl_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic r0; logic w0; logic [7:0] a0;
    logic r1; logic lk; logic w1; logic [7:0] a1;
    logic e0; logic e1; logic es;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [0:NV-1];

  initial begin
    // round-robin from IDLE, continuous reads
    vecs[0]  = '{1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h23, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    // lock bound: one m0 write, then m1 locked writes against a waiting m0
    vecs[8]  = '{1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h51, 1'b1, 1'b1, 1'b1, 8'h60, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h51, 1'b1, 1'b1, 1'b1, 8'h61, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 8'h51, 1'b1, 1'b1, 1'b1, 8'h62, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 8'h51, 1'b1, 1'b1, 1'b1, 8'h63, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 8'h51, 1'b1, 1'b1, 1'b1, 8'h64, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h64, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h65, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    // lock drop after two locked grants while m0 waits
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h70, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 8'h71, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h72, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h72, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'(i * 16'h0101) ^ 16'h3C00;
      shadow[i] = 16'(i * 16'h0101) ^ 16'h3C00;
    end
    mem[8'h12]    = 16'hBEEF;
    shadow[8'h12] = 16'hBEEF;
    model_reset();
    eg0 = 1'b0; eg1 = 1'b0;

    // Bring the design out of X before checking anything.
    rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    @(posedge clk);
    #1;

    // Reset held 2 cycles with both masters requesting reads.
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h12;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h34; m1_lock = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("rst m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("rst m1_gnt", {31'd0, m1_gnt}, 32'd0);
      chk("rst ram_rd", {31'd0, ram_rd}, 32'd0);
      chk("rst ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rst rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      advance();
    end
    rst = 1'b0;
    // N: m0 wins from IDLE
    sample();
    chk("rel m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rel m1_gnt", {31'd0, m1_gnt}, 32'd0);
    advance();
    m0_req = 1'b0;
    // N+1: RAM read strobe for 0x12; m1 gets its turn
    sample();
    chk("lat ram_rd", {31'd0, ram_rd}, 32'd1);
    chk("lat ram_addr", {24'd0, ram_addr}, 32'h12);
    chk("lat m1_gnt", {31'd0, m1_gnt}, 32'd1);
    advance();
    m1_req = 1'b0;
    // N+2: m0 read data returns
    sample();
    chk("lat m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("lat m0_rdata", {16'd0, m0_rdata}, 32'hBEEF);
    chk("lat m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    advance();
    sample();
    chk("lat m1 rvalid", {31'd0, m1_rvalid}, 32'd1);
    advance();

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      m0_req = vecs[i].r0; m0_wr = vecs[i].w0; m0_addr = vecs[i].a0;
      m0_wdata = {vecs[i].a0, ~vecs[i].a0};
      m1_req = vecs[i].r1; m1_lock = vecs[i].lk; m1_wr = vecs[i].w1; m1_addr = vecs[i].a1;
      m1_wdata = {~vecs[i].a1, vecs[i].a1};
      sample();
      chk($sformatf("vec%0d m0_gnt", i), {31'd0, m0_gnt}, {31'd0, vecs[i].e0});
      chk($sformatf("vec%0d m1_gnt", i), {31'd0, m1_gnt}, {31'd0, vecs[i].e1});
      chk($sformatf("vec%0d m0_stall", i), {31'd0, m0_stall}, {31'd0, vecs[i].es});
      advance();
    end
    sample();
    advance();

    // Reset at N+1 of an m1 read: no rvalid, arbiter back to IDLE.
    m1_req = 1'b1; m1_wr = 1'b0; m1_lock = 1'b0; m1_addr = 8'h34;
    sample();
    chk("mid m1_gnt", {31'd0, m1_gnt}, 32'd1);
    advance();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h12;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    m1_req = 1'b1; m1_addr = 8'h35;
    sample();
    chk("mid m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("mid ram_rd", {31'd0, ram_rd}, 32'd0);
    chk("mid idle m0_gnt", {31'd0, m0_gnt}, 32'd1);
    advance();
    m0_req = 1'b0;
    sample();
    advance();
    m1_req = 1'b0;
    sample();
    advance();

    // Randomized traffic; requests are held until the model grants them.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!m0_req || eg0) begin
        m0_req   = ($urandom_range(0, 1) == 1);
        m0_wr    = ($urandom_range(0, 2) == 0);
        m0_addr  = 8'($urandom);
        m0_wdata = 16'($urandom);
      end
      if (!m1_req || eg1) begin
        m1_req   = ($urandom_range(0, 9) < 7);
        m1_lock  = ($urandom_range(0, 9) < 6);
        m1_wr    = ($urandom_range(0, 1) == 0);
        m1_addr  = 8'($urandom);
        m1_wdata = 16'($urandom);
      end
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
